pipe_stage_reg: RTL

Parametrised inter-stage pipeline register, the generic successor of the fixed EX/MEM latch.
- Carries an opaque payload plus a valid bit between two CPU pipeline stages.
- Obeys the global stall vector and the exception flush.
- On a bubble, clears only the payload bits selected by a per-bit mask; all other bits hold.
- Keeps saturating performance counters for stall, bubble and kill events. Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/cpu_pipe_pkg.sv | 36 +++
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants for the inter-stage registers.
// Holds the global stall vector width, the stage index map, the payload
// widths carried across each boundary, and the bubble masks (bit set =
// reload from RESET_VAL on a bubble, bit clear = hold).
package cpu_pipe_pkg;

    localparam int STALL_W   = 6;

    localparam int STG_IF    = 0;
    localparam int STG_ID    = 1;
    localparam int STG_EX    = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    localparam int IFID_W    = 64;
    localparam int IDEX_W    = 128;
    localparam int EXMEM_W   = 104;
    localparam int MEMWB_W   = 72;

    localparam logic [IFID_W-1:0]  IFID_BUBBLE_MASK  = {IFID_W{1'b1}};
    localparam logic [IDEX_W-1:0]  IDEX_BUBBLE_MASK  = {IDEX_W{1'b1}};
    // EX/MEM layout: [103:100] exception type, [99] delay-slot flag,
    // [98:67] PC, [66:0] write enables + data. The exception context must
    // survive a bubble so a late trap still reports the right PC.
    localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE_MASK = {{37{1'b0}}, {67{1'b1}}};
    localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE_MASK = {MEMWB_W{1'b1}};

    // Action taken by a stage register on a clock edge.
    typedef enum logic [1:0] {
        ACT_ADV    = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } pipe_act_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stage performance counters.
// Ports: clk, rst (async, active high), clr (sync clear, wins over inc),
//        inc (count one event), count (current value, sticks at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid, driven by the
// global stall vector and the exception flush, with stall/bubble/kill
// performance counters.
// Ports: clk, rst (async, active high); stall (global stall vector);
//        flush (kill held instruction); in_valid/in_data (upstream);
//        cnt_clr (sync clear of counters); out_valid/out_data (registered);
//        stall_cnt/bubble_cnt/kill_cnt (saturating event counters).
module pipe_stage_reg #(
    parameter int                DATA_W      = 128,
    parameter int                STALL_W     = cpu_pipe_pkg::STALL_W,
    parameter int                STAGE       = 3,
    parameter logic [DATA_W-1:0] BUBBLE_MASK = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] RESET_VAL   = {DATA_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   kill_cnt
);

    import cpu_pipe_pkg::pipe_act_e;
    import cpu_pipe_pkg::ACT_ADV;
    import cpu_pipe_pkg::ACT_HOLD;
    import cpu_pipe_pkg::ACT_BUBBLE;
    import cpu_pipe_pkg::ACT_FLUSH;

    logic              dn;
    pipe_act_e         act;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The last stage has nobody downstream to stall it, so a stall there
    // always drains into a bubble rather than a hold.
    generate
        if (STAGE < STALL_W - 1) begin : g_dn
            assign dn = stall[STAGE+1];
        end else begin : g_top
            assign dn = 1'b0;
        end
    endgenerate

    always_comb begin
        act = ACT_ADV;
        if (flush)
            act = ACT_FLUSH;
        else if (stall[STAGE] && !dn)
            act = ACT_BUBBLE;
        else if (stall[STAGE])
            act = ACT_HOLD;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (act)
            ACT_FLUSH: begin
                valid_d = 1'b0;
                data_d  = RESET_VAL;
            end
            ACT_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = (data_q & ~BUBBLE_MASK) | (RESET_VAL & BUBBLE_MASK);
            end
            ACT_ADV: begin
                // Payload is captured even when in_valid is low.
                valid_d = in_valid;
                data_d  = in_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (act == ACT_HOLD),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (act == ACT_BUBBLE),
        .count (bubble_cnt)
    );

    // Only a live instruction counts as killed.
    sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   ((act == ACT_FLUSH) && valid_q),
        .count (kill_cnt)
    );

endmodule
